pipereg_skid: RTL
=================

Name: pipereg_skid

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One generic stage register with:
  - a valid/ready handshake;
  - a 2-entry skid buffer, so the upstream ready is fully registered;
  - nop/bubble insertion with control-field clearing;
  - flush;
  - a saturating lost-slot performance counter.
- Instantiated between every pair of CPU pipeline stages. Widths are set per instance.

Parameters:
- CTRLW, 8, width of the control field (cleared on nop/flush).
- DATAW, 256, width of the payload (opcode, pc, results, rd, flags; passed unmodified).
- CNTW, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered.
- in_nop  in  1  upstream entry is a bubble.
- in_ctrl  in  CTRLW  upstream control field.
- in_data  in  DATAW  upstream payload.
- nop  in  1  hazard unit forces the captured entry to a bubble.
- flush  in  1  kill all held entries (branch taken/exception).
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream not stalled.
- out_nop  out  1  presented entry is a bubble.
- out_ctrl  out  CTRLW  control field; 0 whenever out_valid=0 or out_nop=1.
- out_data  out  DATAW  payload; holds last value when out_valid=0.
- cnt_clr  in  1  synchronous clear of bubble_cnt.
- bubble_cnt  out  CNTW  lost downstream issue slots.

Behaviour:
- State:
  - Main entry M = {vld, nop, ctrl, data}; drives the out_* ports directly.
  - Skid entry S = {vld, nop, ctrl, data}.
- in_ready = ~S.vld, held as a registered copy.
- Invariant: S.vld=1 implies M.vld=1.
- Reset (rst_n=0 at posedge):
  - M.vld=0, M.nop=1, M.ctrl=0, M.data=0.
  - S.vld=0.
  - in_ready=1 after the reset edge.
  - bubble_cnt=0.
  - Reset mid-stall discards both entries.
- Definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - Captured entry E: nop = in_nop|nop; ctrl = (in_nop|nop) ? 0 : in_ctrl; data = in_data.
- Priority at each posedge: reset > flush > normal.
- Flush:
  - M.vld=0, M.ctrl=0, M.nop=1, S.vld=0, in_ready=1.
  - An input accepted in the same cycle is discarded. Upstream treats flush as a kill of its own entry.
- Normal operation, first matching case:
  1. S.vld & drain: M<=S, S.vld<=0, in_ready<=1.
  2. ~M.vld | drain: M<=E if accept, else M.vld<=0 (ctrl<=0, nop<=1, data held).
  3. M.vld & ~out_ready & accept: S<=E, in_ready<=0. M holds.
  4. Otherwise all entries hold.
- Latency and throughput:
  - 1 cycle in→out when not stalled.
  - Full throughput: one entry per cycle with out_ready held 1.
  - After out_ready deasserts, at most one further entry is absorbed by S. in_ready drops on the following cycle.
- Counter:
  - Increments each cycle where out_ready=1 & (~out_valid | out_nop).
  - Saturates at 2^CNTW-1, no wrap.
  - Counts during flush cycles with the pre-edge values.
  - cnt_clr wins over increment; reset wins over cnt_clr.
- Ordering: entries leave in arrival order; no duplication or loss except via flush/reset.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then in_valid=1, ctrl=0x5A, data=0x1234, out_ready=1 → out_valid=1, out_ctrl=0x5A, out_data=0x1234 one cycle after the reset release edge. in_ready=1 throughout.
2. Stream 4 entries (data 1..4) with out_ready=1; drop out_ready=0 while entry 2 is presented → entry 3 held in S; in_ready=0 next cycle. On re-raising out_ready: order 2,3,4 out, no loss or duplication.
3. nop=1 while capturing ctrl=0xFF, data=0xAB → out_valid=1, out_nop=1, out_ctrl=0, out_data=0xAB. bubble_cnt +1 for that cycle with out_ready=1.
4. Flush with both M and S full plus simultaneous accept → next cycle out_valid=0, out_ctrl=0, in_ready=1. No old entry ever appears.
5. CNTW=4, idle with out_ready=1 for 20 cycles → bubble_cnt saturates at 15. cnt_clr=1 plus a bubble cycle → 0.
6. Assert rst_n=0 while stalled with S full → both entries gone, out_valid=0, in_ready=1, bubble_cnt=0.

Source files
------------

// File: rtl/pipereg_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// bubble insertion, flush and a saturating lost-slot counter.
module pipereg_skid #(
    parameter int CTRLW = 8,
    parameter int DATAW = 256,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_nop,
    input  logic [CTRLW-1:0] in_ctrl,
    input  logic [DATAW-1:0] in_data,
    input  logic             nop,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_nop,
    output logic [CTRLW-1:0] out_ctrl,
    output logic [DATAW-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNTW-1:0]  bubble_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic             m_vld;
    logic             m_nop;
    logic [CTRLW-1:0] m_ctrl;
    logic [DATAW-1:0] m_data;
    logic             s_vld;
    logic             s_nop;
    logic [CTRLW-1:0] s_ctrl;
    logic [DATAW-1:0] s_data;
    logic             ready_q;
    logic [CNTW-1:0]  cnt;

    logic             accept;
    logic             drain;
    logic             e_nop;
    logic [CTRLW-1:0] e_ctrl;

    assign accept = in_valid & ready_q;
    assign drain  = m_vld & out_ready;
    assign e_nop  = in_nop | nop;
    assign e_ctrl = e_nop ? '0 : in_ctrl;

    // Control fields are cleared at capture time, so M.ctrl is already zero whenever
    // the entry is invalid or a bubble and can drive out_ctrl directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_vld   <= 1'b0;
            m_nop   <= 1'b1;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_vld   <= 1'b0;
            s_nop   <= 1'b1;
            s_ctrl  <= '0;
            s_data  <= '0;
            ready_q <= 1'b1;
        end else if (flush) begin
            m_vld   <= 1'b0;
            m_nop   <= 1'b1;
            m_ctrl  <= '0;
            s_vld   <= 1'b0;
            ready_q <= 1'b1;
        end else if (s_vld && drain) begin
            m_vld   <= 1'b1;
            m_nop   <= s_nop;
            m_ctrl  <= s_ctrl;
            m_data  <= s_data;
            s_vld   <= 1'b0;
            ready_q <= 1'b1;
        end else if (!m_vld || drain) begin
            if (accept) begin
                m_vld  <= 1'b1;
                m_nop  <= e_nop;
                m_ctrl <= e_ctrl;
                m_data <= in_data;
            end else begin
                m_vld  <= 1'b0;
                m_nop  <= 1'b1;
                m_ctrl <= '0;
            end
        end else if (accept) begin
            // Downstream stalled while M is full: park the in-flight entry in the skid slot.
            s_vld   <= 1'b1;
            s_nop   <= e_nop;
            s_ctrl  <= e_ctrl;
            s_data  <= in_data;
            ready_q <= 1'b0;
        end
    end

    // A slot is lost whenever downstream could take something but gets nothing useful.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (out_ready && (!m_vld || m_nop) && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = m_vld;
    assign out_nop    = m_nop;
    assign out_ctrl   = m_ctrl;
    assign out_data   = m_data;
    assign bubble_cnt = cnt;

endmodule
